// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic valid/ready stage register with a two-entry skid buffer
// Defining PIPE_STAGE_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 134,
  parameter int unsigned FLUSH_ZERO = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam bit ZERO_DATA = (FLUSH_ZERO != 0);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic              accept;
  logic              emit;

  // Ready depends only on the skid flop, so out_ready never reaches in_ready combinationally.
  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_d_q;

  assign accept = in_valid & ~skid_v_q;
  assign emit   = main_v_q & out_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (ZERO_DATA) begin
        main_d_d = '0;
        skid_d_d = '0;
      end
    end else begin
      case ({main_v_q, skid_v_q})
        2'b00: begin
          if (accept) begin
            main_v_d = 1'b1;
            main_d_d = in_data;
          end
        end
        2'b10: begin
          if (accept && emit) begin
            main_d_d = in_data;
          end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data;
          end else if (emit) begin
            main_v_d = 1'b0;
            if (ZERO_DATA) main_d_d = '0;
          end
        end
        2'b11: begin
          if (emit) begin
            main_d_d = skid_d_q;
            skid_v_d = 1'b0;
            if (ZERO_DATA) skid_d_d = '0;
          end
        end
        default: begin
          // Unreachable skid-only state: recover to EMPTY.
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      if (ZERO_DATA) begin
        main_d_q <= '0;
        skid_d_q <= '0;
      end
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_v_q && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && (main_v_q || skid_v_q) && flush_cnt_q != 32'hFFFF_FFFF) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed vector table plus randomized queue-model check of pipe_stage_reg
// Counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          clr, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .FLUSH_ZERO(1)) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct {
    logic          c, f, iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          ev, er;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic f, input logic iv, input logic [DW-1:0] d,
                     input logic ordy, input logic ev, input logic er, input logic [DW-1:0] ed);
    vec_t v;
    v.c = c; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ev = ev; v.er = er; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic f, input logic iv, input logic [DW-1:0] d,
                       input logic ordy);
    clr = c; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] mq[$];
  logic          rc, rf, riv, ror;
  logic [DW-1:0] rd;
  logic [31:0]   stall_m, flush_m;

  initial begin
    drive(1'b1, 1'b0, 1'b1, 8'h55, 1'b0);

    //   clr   flush iv    data   ordy  -> valid ready data
    add(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00);
    add(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11);
    add(1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22);
    add(1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1);
    add(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'hA1);
    add(1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'hA1);
    add(1'b0, 1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA2);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 1'b1, 8'hC1);
    add(1'b0, 1'b0, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 8'hC1);
    add(1'b0, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b1, 8'hD1, 1'b0, 1'b1, 1'b1, 8'hD1);
    add(1'b0, 1'b1, 1'b1, 8'hD2, 1'b1, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b1, 8'hE1, 1'b0, 1'b1, 1'b1, 8'hE1);
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].c, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].er));
      check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].ed));
`ifdef PIPE_STAGE_PERF_EN
      if (i == 14) check("flush_cnt_after_full_flush", flush_cnt, 32'd1);
      if (i == 17) check("flush_cnt_after_one_flush", flush_cnt, 32'd2);
      if (i == 20) begin
        check("clr_beats_flush_flush_cnt", flush_cnt, 32'd0);
        check("clr_beats_flush_stall_cnt", stall_cnt, 32'd0);
      end
`endif
    end

`ifdef PIPE_STAGE_PERF_EN
    drive(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    check("stall_cnt_5", stall_cnt, 32'd5);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #2;
    release dut.stall_cnt_q;
    for (int k = 0; k < 4; k++) tick();
    check("stall_cnt_saturate", stall_cnt, 32'hFFFF_FFFF);
`endif

    stall_m = 32'd0;
    flush_m = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      rc  = (i == 0) || ($urandom_range(0, 99) == 0);
      rf  = ($urandom_range(0, 29) == 0);
      riv = ($urandom_range(0, 3) != 0);
      ror = ($urandom_range(0, 2) != 0);
      rd  = DW'($urandom);
      drive(rc, rf, riv, rd, ror);

      if (rc) begin
        stall_m = 32'd0;
        flush_m = 32'd0;
        mq.delete();
      end else begin
        if (mq.size() > 0 && !ror && stall_m != 32'hFFFF_FFFF) stall_m++;
        if (rf && mq.size() > 0 && flush_m != 32'hFFFF_FFFF) flush_m++;
        if (rf) begin
          mq.delete();
        end else begin
          logic can_take;
          can_take = (mq.size() < 2);
          if (mq.size() > 0 && ror) void'(mq.pop_front());
          if (riv && can_take) mq.push_back(rd);
        end
      end

      tick();
      check("rnd_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("rnd_in_ready", 32'(in_ready), 32'(mq.size() < 2));
      check("rnd_out_data", 32'(out_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
`ifdef PIPE_STAGE_PERF_EN
      check("rnd_stall_cnt", stall_cnt, stall_m);
      check("rnd_flush_cnt", flush_cnt, flush_m);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
